// File: rtl/pe_result_collector.sv
// pe_result_collector: buffers last-PE results in a FIFO, counts them against a job total, serves host reads.
// Optional RESULT_RELU_EN: negative pushed words are stored as zero.
module pe_result_collector #(
    parameter int DataWidth   = 32,
    parameter int BufferWidth = 4,
    parameter int BufferSize  = 16,
    parameter int CountWidth  = 16
) (
    input  logic                  clk,
    input  logic                  aclr,
    input  logic                  clk_en,
    input  logic                  Start,
    input  logic [CountWidth-1:0] ExpectCount,
    input  logic [DataWidth-1:0]  O_DataIn,
    input  logic                  O_DataInValid,
    output logic                  O_DataInRdy,
    input  logic                  Rd_Req,
    output logic [DataWidth-1:0]  Rd_Data,
    output logic                  Rd_Valid,
    output logic                  Empty,
    output logic [CountWidth-1:0] Accepted,
    output logic                  Busy,
    output logic                  Done
);
    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;
    state_t                 state_q, state_d;
    logic [BufferWidth-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [BufferWidth:0]   cnt_q, cnt_d;
    logic [CountWidth-1:0]  acc_q, acc_d, exp_q, exp_d;
    logic [DataWidth-1:0]   rd_data_q, rd_data_d, wdata;
    logic                   rd_valid_q, rd_valid_d, full, empty, push, pop;
    logic [DataWidth-1:0]   mem [BufferSize];

    assign full        = cnt_q == (BufferWidth+1)'(BufferSize);
    assign empty       = cnt_q == '0;
    // Rdy ignores Valid so the PE can use it as a lookahead stall; a same-cycle pop never frees a full slot
    assign O_DataInRdy = (state_q == COLLECT) && !full;
    assign push        = O_DataInValid && O_DataInRdy;
    assign pop         = Rd_Req && !empty;
`ifdef RESULT_RELU_EN
    assign wdata = O_DataIn[DataWidth-1] ? '0 : O_DataIn;
`else
    assign wdata = O_DataIn;
`endif

    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        wp_d       = push ? wp_q + 1'b1 : wp_q;
        rp_d       = pop ? rp_q + 1'b1 : rp_q;
        cnt_d      = cnt_q + (BufferWidth+1)'(push) - (BufferWidth+1)'(pop);
        acc_d      = push ? acc_q + 1'b1 : acc_q;
        rd_valid_d = pop;
        rd_data_d  = pop ? mem[rp_q] : rd_data_q;
        case (state_q)
            IDLE: if (Start) begin
                exp_d   = ExpectCount;
                acc_d   = '0;
                state_d = (ExpectCount == '0) ? DONE : COLLECT;
            end
            COLLECT: if (push && acc_d == exp_q) state_d = DRAIN;
            DRAIN:   if (empty && !pop) state_d = DONE;
            DONE:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (aclr) begin
                state_q    <= IDLE;
                wp_q       <= '0;
                rp_q       <= '0;
                cnt_q      <= '0;
                acc_q      <= '0;
                exp_q      <= '0;
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                state_q    <= state_d;
                wp_q       <= wp_d;
                rp_q       <= rp_d;
                cnt_q      <= cnt_d;
                acc_q      <= acc_d;
                exp_q      <= exp_d;
                rd_data_q  <= rd_data_d;
                rd_valid_q <= rd_valid_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clk_en && push) mem[wp_q] <= wdata;
    end

    assign Rd_Data  = rd_data_q;
    assign Rd_Valid = rd_valid_q;
    assign Empty    = empty;
    assign Accepted = acc_q;
    assign Busy     = state_q != IDLE;
    assign Done     = state_q == DONE;
endmodule

// File: tb/tb_pe_result_collector.sv
// tb_pe_result_collector: directed jobs plus a read-side scoreboard for pe_result_collector.
module tb_pe_result_collector;
    localparam int DW = 32;
    localparam int CW = 16;
    logic          clk = 0, aclr = 1, clk_en = 1, Start = 0, O_DataInValid = 0, Rd_Req = 0;
    logic [CW-1:0] ExpectCount = '0;
    logic [DW-1:0] O_DataIn = '0;
    logic          O_DataInRdy, Rd_Valid, Empty, Busy, Done;
    logic [DW-1:0] Rd_Data;
    logic [CW-1:0] Accepted;
    int            n_cmp = 0, n_err = 0, done_cnt = 0;
    bit            chk = 0;
    logic [DW-1:0] q[$];
    logic          m_rv = 0;
    logic [DW-1:0] m_rd = '0;

    always #5 clk = ~clk;

    pe_result_collector dut (
        .clk(clk), .aclr(aclr), .clk_en(clk_en), .Start(Start), .ExpectCount(ExpectCount),
        .O_DataIn(O_DataIn), .O_DataInValid(O_DataInValid), .O_DataInRdy(O_DataInRdy),
        .Rd_Req(Rd_Req), .Rd_Data(Rd_Data), .Rd_Valid(Rd_Valid), .Empty(Empty),
        .Accepted(Accepted), .Busy(Busy), .Done(Done)
    );

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] w);
`ifdef RESULT_RELU_EN
        return w[DW-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 60 && Busy; k++) tick();
        check(tag, Busy, 0);
    endtask

    // Scoreboard: words enter on an observed handshake, leave when the model predicts a read
    always @(negedge clk) begin
        if (Done) done_cnt++;
        if (chk) begin
            check("mdl_rv", Rd_Valid, m_rv);
            check("mdl_rd", Rd_Data, m_rd);
        end
        if (clk_en) begin
            if (aclr) begin
                q.delete();
                m_rv = 0;
                m_rd = '0;
            end else begin
                m_rv = Rd_Req && q.size() > 0;
                if (m_rv) m_rd = q.pop_front();
                if (O_DataInValid && O_DataInRdy) q.push_back(relu(O_DataIn));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int i, rd_i, d0;
        logic a;
        tick();
        aclr = 0;
        chk  = 1;
        check("rst_empty", Empty, 1);
        check("rst_busy", Busy, 0);
        check("rst_acc", Accepted, 0);
        check("rst_rdy", O_DataInRdy, 0);
        check("rst_rv", Rd_Valid, 0);
        check("rst_rd", Rd_Data, 0);
        check("rst_done", Done, 0);
        // basic job of three
        d0 = done_cnt;
        Start = 1; ExpectCount = 3; tick(); Start = 0;
        check("t1_rdy", O_DataInRdy, 1);
        check("t1_busy", Busy, 1);
        O_DataInValid = 1;
        for (int k = 3; k < 6; k++) begin O_DataIn = k; tick(); end
        O_DataInValid = 0;
        check("t1_acc", Accepted, 3);
        check("t1_rdy_drain", O_DataInRdy, 0);
        check("t1_busy_drain", Busy, 1);
        Rd_Req = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t1_rv", Rd_Valid, 1);
            check("t1_rd", Rd_Data, 3 + k);
        end
        Rd_Req = 0;
        tick();
        check("t1_rv_end", Rd_Valid, 0);
        wait_idle("t1_idle");
        check("t1_done", done_cnt - d0, 1);
        // overflow job: fill to full, then drain while streaming
        Start = 1; ExpectCount = 20; tick(); Start = 0;
        O_DataInValid = 1; i = 0;
        for (int k = 0; k < 25; k++) begin
            O_DataIn = i; a = O_DataInRdy; tick();
            if (a) i++;
        end
        check("t2_pushes", i, 16);
        check("t2_full_rdy", O_DataInRdy, 0);
        check("t2_acc16", Accepted, 16);
        Rd_Req = 1; O_DataIn = i; tick();
        check("t2_rdy_re", O_DataInRdy, 1);
        rd_i = 0;
        for (int k = 0; k < 80 && (Busy || Rd_Valid); k++) begin
            if (Rd_Valid) begin check("t2_seq", Rd_Data, rd_i); rd_i++; end
            O_DataInValid = i < 20; O_DataIn = i;
            a = O_DataInRdy && O_DataInValid;
            tick();
            if (a) i++;
        end
        Rd_Req = 0; O_DataInValid = 0;
        check("t2_nread", rd_i, 20);
        check("t2_acc20", Accepted, 20);
        check("t2_idle", Busy, 0);
        // simultaneous push and pop with five buffered
        Start = 1; ExpectCount = 20; tick(); Start = 0;
        O_DataInValid = 1;
        for (int k = 0; k < 5; k++) begin O_DataIn = 100 + k; tick(); end
        O_DataIn = 105; Rd_Req = 1; tick();
        O_DataInValid = 0; Rd_Req = 0;
        check("t3_rv", Rd_Valid, 1);
        check("t3_rd", Rd_Data, 100);
        check("t3_acc", Accepted, 6);
        Rd_Req = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_drain", Rd_Data, 101 + k);
            check("t3_empty", Empty, k == 4);
        end
        // read while empty
        tick();
        check("t4_rv", Rd_Valid, 0);
        check("t4_rd", Rd_Data, 105);
        Rd_Req = 0;
        // clock-enable freeze
        O_DataInValid = 1; O_DataIn = 200; tick(); O_DataIn = 201; tick();
        clk_en = 0; O_DataIn = 300; Rd_Req = 1; Start = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t7_acc", Accepted, 8);
            check("t7_empty", Empty, 0);
            check("t7_busy", Busy, 1);
            check("t7_rv", Rd_Valid, 0);
            check("t7_rd", Rd_Data, 105);
        end
        clk_en = 1; Rd_Req = 0; Start = 0;
        for (int k = 0; k < 5; k++) begin O_DataIn = 210 + k; tick(); end
        O_DataInValid = 0;
        check("t7_acc2", Accepted, 13);
        // reset mid-collect with seven buffered
        aclr = 1; tick(); aclr = 0;
        check("t6_busy", Busy, 0);
        check("t6_empty", Empty, 1);
        check("t6_acc", Accepted, 0);
        check("t6_rdy", O_DataInRdy, 0);
        // zero-length job, then Start while busy
        d0 = done_cnt;
        Start = 1; ExpectCount = 0; tick(); Start = 0;
        check("t5_busy", Busy, 1);
        check("t5_done", Done, 1);
        tick();
        check("t5_idle", Busy, 0);
        check("t5_done_off", Done, 0);
        check("t5_dcnt", done_cnt - d0, 1);
        Start = 1; ExpectCount = 2; tick(); ExpectCount = 9; tick(); Start = 0;
        O_DataInValid = 1; O_DataIn = 7; tick(); O_DataIn = 8; tick(); O_DataInValid = 0;
        check("t5_acc", Accepted, 2);
        check("t5_rdy", O_DataInRdy, 0);
        Rd_Req = 1; tick(); tick(); Rd_Req = 0;
        wait_idle("t5_idle2");
        check("t5_acc_hold", Accepted, 2);
`ifdef RESULT_RELU_EN
        Start = 1; ExpectCount = 2; tick(); Start = 0;
        O_DataInValid = 1; O_DataIn = 32'hFFFF_FFF6; tick(); O_DataIn = 32'h0000_000A; tick();
        O_DataInValid = 0;
        Rd_Req = 1;
        tick(); check("relu_neg", Rd_Data, 0);
        tick(); check("relu_pos", Rd_Data, 10);
        Rd_Req = 0;
        wait_idle("relu_idle");
`endif
        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pe_result_collector.md
Name: pe_result_collector

Overview:
- Downstream stage of the last PE in a PE chain; consumes the O_DataOut / O_DataOutValid result stream and drives that PE's O_DataOutRdy stall gate.
- Buffers results in a 16-entry FIFO and counts them against a host-programmed expected total.
- Exposes the results to the Nios II custom-instruction side through a 1-cycle-latency read port, with a done pulse when the job is collected and drained.

Parameters:
- DataWidth, 32, result word width.
- BufferWidth, 4, FIFO address width.
- BufferSize, 16, FIFO depth; must equal 2**BufferWidth.
- CountWidth, 16, width of expected/accepted result counters.

Ports:
- clk  input  1  clock.
- aclr  input  1  reset; synchronous, active-high.
- clk_en  input  1  clock enable; when low, all registers hold.
- Start  input  1  job start strobe; sampled only in IDLE.
- ExpectCount  input  CountWidth  number of results in the job; latched on an accepted Start.
- O_DataIn  input  DataWidth  result word from the last PE's O_DataOut.
- O_DataInValid  input  1  result valid (from the PE's O_DataOutValid).
- O_DataInRdy  output  1  accept enable; wired to the PE's O_DataOutRdy.
- Rd_Req  input  1  host read request.
- Rd_Data  output  DataWidth  read data, registered.
- Rd_Valid  output  1  one-cycle pulse qualifying Rd_Data.
- Empty  output  1  FIFO empty.
- Accepted  output  CountWidth  results accepted in the current job.
- Busy  output  1  state is not IDLE.
- Done  output  1  one-cycle completion pulse.

Behaviour:
- All registers update only when clk_en=1, and aclr is honoured only on an enabled edge.
- aclr=1 resets all of the following:
  - state to IDLE;
  - FIFO pointers and occupancy to 0, so Empty=1;
  - Accepted, Rd_Data, Rd_Valid and Done to 0;
  - latched ExpectCount to 0.
- aclr during an active job discards the job and all buffered data.
- O_DataInRdy = (state==COLLECT) & ~Full. This is combinational and independent of O_DataInValid, because the PE uses it as a lookahead stall.
- Push = O_DataInValid & O_DataInRdy. Each push writes the FIFO tail and increments Accepted.
- Pop = Rd_Req & ~Empty. On the next clk_en edge:
  - Rd_Data takes the head word;
  - Rd_Valid=1 for exactly one cycle;
  - Rd_Req while Empty is ignored, with Rd_Valid=0 and Rd_Data held.
- Push and pop in the same cycle:
  - both are performed and occupancy is unchanged;
  - at Full, pop-then-push is not allowed: Rdy stays low while Full, even if a pop occurs that cycle.
- Pointers wrap modulo BufferSize. Full/Empty are derived from an occupancy counter of width BufferWidth+1.
- Reads are permitted in every state, so the host may drain while collection is in progress.
- FSM states and transitions:
  - IDLE: Start=1 latches ExpectCount and clears Accepted.
    - If ExpectCount=0, go to DONE.
    - Otherwise go to COLLECT.
  - COLLECT: when a push makes Accepted == ExpectCount, go to DRAIN. Rdy drops on the following cycle.
  - DRAIN: when Empty=1 and no pop is in progress, go to DONE.
  - DONE: Done=1 for one cycle, then go to IDLE.
- Start outside IDLE is ignored.
- Busy = (state != IDLE).
- O_DataInValid outside COLLECT is ignored (Rdy=0) and data is not captured.
- Accepted saturates at ExpectCount. It holds its value after DONE until the next accepted Start.

Optional Feature:
- Macro: RESULT_RELU_EN.
- Defined: words are treated as two's-complement. Any pushed word with the MSB set is written to the FIFO as 0. Accepted still counts it.
- Undefined: words are stored unmodified. No extra logic is present.

Test Plan:
- Reset then Start with ExpectCount=3; push 3, 4, 5 with Valid held high.
  - Required: Rdy high in COLLECT; Accepted=3; DRAIN entered.
  - Then 3 Rd_Req cycles return 3, 4, 5, each with a single Rd_Valid pulse one cycle after the request; Done pulses once; Busy=0.
- ExpectCount=20 with no reads; Valid held high.
  - Required: exactly 16 pushes; Rdy=0 while Full; Accepted=16.
  - Then one Rd_Req per cycle: Rdy reasserts the cycle after the first pop, and the stream resumes to Accepted=20 with no word lost or duplicated (values 0..19 in order).
- Simultaneous push and Rd_Req with 5 entries present.
  - Required: occupancy stays 5 and the read returns the oldest word.
- Rd_Req while Empty → Rd_Valid=0 and Rd_Data unchanged.
- Start with ExpectCount=0 → DONE on the next edge and a single Done pulse; Start while Busy is ignored (ExpectCount unchanged).
- aclr asserted mid-COLLECT with 7 buffered → next cycle: IDLE, Empty=1, Accepted=0, Rdy=0.
- clk_en=0 for 4 cycles mid-job → state, pointers and outputs frozen.
- With RESULT_RELU_EN: pushing 0xFFFFFFF6 then 0x0000000A reads back 0 then 10.
